button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Debounced multi-button event source. One shared sample tick feeds per-channel
// debouncers, and a round-robin arbiter drains them into a ready/valid event port.
// Optional long-press events are enabled with macro BUTTON_LONG_PRESS_EN.
module button_event_arbiter #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 5000,
    parameter int STABLE_TICKS = 100,
    parameter int LONG_TICKS   = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         i_btn,
    output logic [NUM_BTN-1:0]         o_btn_state,
    output logic                       o_evt_valid,
    input  logic                       i_evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] o_evt_id,
    output logic [1:0]                 o_evt_type,
    output logic                       o_evt_drop
);
    localparam int IDW = $clog2(NUM_BTN);
    localparam int PW  = $clog2(TICK_DIV);
    localparam int SW  = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

    logic [1:0]                  r_rst_sync;
    logic                        w_rst_n;
    logic [NUM_BTN-1:0]          r_meta, r_sync, r_state, r_pend, r_ptype;
    logic [NUM_BTN-1:0][SW-1:0]  r_cnt;
    logic [PW-1:0]               r_presc;
    logic                        w_tick;
    logic [NUM_BTN-1:0]          w_hit, w_req, w_clr_pend, w_clr_long;
    logic [NUM_BTN-1:0]          w_set_long, w_long_pend;
    logic [IDW-1:0]              r_ptr, w_gnt;
    logic                        w_found, w_load, w_sel_long, w_drop;
    logic                        r_valid, r_drop;
    logic [IDW-1:0]              r_id;
    logic [1:0]                  r_type;

    // Assert follows rst_n immediately; release is retimed to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_meta  <= '0;
            r_sync  <= '0;
            r_presc <= '0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end
    assign w_tick = (r_presc == PRESC_LAST);

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_BTN; k++)
            w_hit[k] = w_tick && (r_sync[k] != r_state[k]) && (r_cnt[k] == STABLE_LAST);
    end

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_req   = r_pend | w_long_pend;
        for (int i = 0; i < NUM_BTN; i++) begin
            idx = (int'(r_ptr) + i) % NUM_BTN;
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_gnt   = IDW'(idx);
            end
        end
        w_load = w_found && (!r_valid || i_evt_ready);
        // A pending release is younger than a pending long-press; a pending press is older.
        w_sel_long = w_long_pend[w_gnt] && (!r_pend[w_gnt] || r_ptype[w_gnt]);
        w_clr_pend = '0;
        w_clr_long = '0;
        if (w_load) begin
            w_clr_pend[w_gnt] = !w_sel_long;
            w_clr_long[w_gnt] = w_sel_long;
        end
        w_drop = |(w_hit & r_pend & ~w_clr_pend) | |(w_set_long & w_long_pend & ~w_clr_long);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt   <= '0;
            r_state <= '0;
            r_pend  <= '0;
            r_ptype <= '0;
        end else begin
            for (int k = 0; k < NUM_BTN; k++) begin
                if (r_sync[k] == r_state[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_hit[k]) begin
                    r_cnt[k]   <= '0;
                    r_state[k] <= ~r_state[k];
                end else if (w_tick) begin
                    r_cnt[k] <= r_cnt[k] + SW'(1);
                end
                if (w_hit[k] && !(r_pend[k] && !w_clr_pend[k])) begin
                    r_pend[k]  <= 1'b1;
                    r_ptype[k] <= r_state[k];
                end else if (w_clr_pend[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);

    logic [NUM_BTN-1:0][HW-1:0] r_hold;
    logic [NUM_BTN-1:0]         r_ldone, r_long;

    always_comb begin
        w_set_long = '0;
        for (int k = 0; k < NUM_BTN; k++)
            w_set_long[k] = w_tick && r_state[k] && !r_ldone[k] && (r_hold[k] == LONG_LAST);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hold  <= '0;
            r_ldone <= '0;
            r_long  <= '0;
        end else begin
            for (int k = 0; k < NUM_BTN; k++) begin
                if (!r_state[k]) begin
                    r_hold[k]  <= '0;
                    r_ldone[k] <= 1'b0;
                end else if (w_set_long[k]) begin
                    r_ldone[k] <= 1'b1;
                end else if (w_tick && !r_ldone[k]) begin
                    r_hold[k] <= r_hold[k] + HW'(1);
                end
                if (w_set_long[k] && !(r_long[k] && !w_clr_long[k])) r_long[k] <= 1'b1;
                else if (w_clr_long[k])                               r_long[k] <= 1'b0;
            end
        end
    end
    assign w_long_pend = r_long;
`else
    assign w_set_long  = '0;
    assign w_long_pend = '0;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_type  <= 2'b00;
            r_ptr   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_load) begin
                r_valid <= 1'b1;
                r_id    <= w_gnt;
                r_type  <= w_sel_long ? 2'b10 : {1'b0, r_ptype[w_gnt]};
                r_ptr   <= (w_gnt == IDW'(NUM_BTN - 1)) ? '0 : w_gnt + IDW'(1);
            end else if (i_evt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_btn_state = r_state;
    assign o_evt_valid = r_valid;
    assign o_evt_id    = r_id;
    assign o_evt_type  = r_type;
    assign o_evt_drop  = r_drop;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: expected {id,type} pairs are queued as
// buttons are driven and popped when the DUT hands an event over.
module tb_button_event_arbiter;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] i_btn = '0;
  logic          i_evt_ready = 1'b1;
  logic [NB-1:0] o_btn_state;
  logic          o_evt_valid;
  logic [1:0]    o_evt_id;
  logic [1:0]    o_evt_type;
  logic          o_evt_drop;

  int checks = 0, failures = 0, n_unexp = 0, n_drop = 0, cyc = 0;
  logic [3:0] exp_q[$];
  int         acc_cyc[$];

  button_event_arbiter #(.NUM_BTN(NB), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(6)) dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .o_btn_state(o_btn_state),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready), .o_evt_id(o_evt_id),
    .o_evt_type(o_evt_type), .o_evt_drop(o_evt_drop));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  // Handshake completes on the next posedge; sample mid-cycle.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n) begin
      if (o_evt_drop) n_drop++;
      if (o_evt_valid && i_evt_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) n_unexp++;
        else begin
          e = exp_q.pop_front();
          chk("evt_id", o_evt_id, e[3:2]);
          chk("evt_type", o_evt_type, e[1:0]);
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input int ty);
    exp_q.push_back({2'(id), 2'(ty)});
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc_wait(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc_wait(3);
    rst_n = 1'b1;
    cyc_wait(4);
  endtask

  initial begin
    cyc_wait(3);
    chk("rst_valid", o_evt_valid, 0);
    chk("rst_state", o_btn_state, 0);
    chk("rst_id", o_evt_id, 0);
    chk("rst_type", o_evt_type, 0);
    chk("rst_drop", o_evt_drop, 0);
    rst_n = 1'b1;
    cyc_wait(4);

    // single press on channel 1
    push(1, 0);
    i_btn[1] = 1'b1;
    drain("t30_press", 40);
    chk("t30_state", o_btn_state[1], 1);
    cyc_wait(5);
    chk("t30_idle_valid", o_evt_valid, 0);

    // bounce shorter than the stability window
    for (int i = 0; i < 17; i++) begin
      i_btn[0] = ~i_btn[0];
      cyc_wait(6);
    end
    i_btn[0] = 1'b0;
    cyc_wait(20);
    chk("t31_state", o_btn_state[0], 0);
    chk("t31_unexp", n_unexp, 0);

    // four simultaneous presses from a fresh pointer
    i_btn = '0;
    do_reset();
    acc_cyc.delete();
    for (int k = 0; k < NB; k++) push(k, 0);
    i_btn = 4'hF;
    drain("t32_press", 40);
    chk("t32_count", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4) chk("t32_consec", acc_cyc[3] - acc_cyc[0], 3);
    for (int k = 0; k < NB; k++) push(k, 1);
    i_btn = 4'h0;
    drain("t32_release", 40);

    // stalled consumer: press held in output, release waits in its slot
    i_evt_ready = 1'b0;
    n_drop = 0;
    i_btn[2] = 1'b1; push(2, 0);
    cyc_wait(25);
    i_btn[2] = 1'b0; push(2, 1);
    cyc_wait(25);
    chk("t33_valid", o_evt_valid, 1);
    chk("t33_id", o_evt_id, 2);
    chk("t33_type", o_evt_type, 0);
    chk("t33_drop", n_drop, 0);
    chk("t33_held", exp_q.size(), 2);
    i_evt_ready = 1'b1;
    drain("t33_drain", 20);

    // stalled consumer: third edge overflows the one-entry slot
    i_evt_ready = 1'b0;
    i_btn[2] = 1'b1; push(2, 0);
    cyc_wait(25);
    i_btn[2] = 1'b0; push(2, 1);
    cyc_wait(25);
    i_btn[2] = 1'b1;
    cyc_wait(25);
    chk("t34_drop", n_drop, 1);
    chk("t34_state", o_btn_state[2], 1);
    chk("t34_id", o_evt_id, 2);
    i_evt_ready = 1'b1;
    drain("t34_drain", 20);
    i_btn[2] = 1'b0; push(2, 1);
    drain("t34_release", 40);
    chk("t34_drop_final", n_drop, 1);

    // reset with an event in flight, button held through release
    i_evt_ready = 1'b0;
    i_btn[1] = 1'b1; push(1, 0);
    cyc_wait(25);
    chk("t35_pre_valid", o_evt_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t35_valid", o_evt_valid, 0);
    chk("t35_state", o_btn_state, 0);
    chk("t35_id", o_evt_id, 0);
    chk("t35_type", o_evt_type, 0);
    chk("t35_drop", o_evt_drop, 0);
    exp_q.delete();
    cyc_wait(3);
    rst_n = 1'b1;
    i_evt_ready = 1'b1;
    push(1, 0);
    drain("t35_held_press", 60);
    chk("t35_state_after", o_btn_state[1], 1);
    i_btn[1] = 1'b0; push(1, 1);
    drain("t35_release", 40);

`ifdef BUTTON_LONG_PRESS_EN
    i_btn[0] = 1'b1;
    push(0, 0); push(0, 2);
    cyc_wait(14 * 4 + 10);
    chk("long_drain", exp_q.size(), 0);
    i_btn[0] = 1'b0; push(0, 1);
    drain("long_release", 40);
`endif

    cyc_wait(10);
    chk("final_idle_valid", o_evt_valid, 0);
    chk("unexpected_events", n_unexp, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
